// File: rtl/lsu_ctrl_if.sv
// Bundle of EXU request, data-memory handshake and WBU result signals for lsu_ctrl.
// The master side is the load/store controller; the slave side is the surrounding EXU/memory/WBU.
interface lsu_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_wen;
   logic [2:0]              in_sel;
   logic [ADDR_WIDTH-1:0]   in_addr;
   logic [DATA_WIDTH-1:0]   in_wdata;

   logic                    mem_req;
   logic                    mem_ack;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH/8-1:0] mem_wstrb;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    mem_rvalid;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_err;

   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_err;

   modport master (
      input  in_valid, in_wen, in_sel, in_addr, in_wdata,
      input  mem_ack, mem_rvalid, mem_rdata, mem_err,
      input  out_ready,
      output in_ready,
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output out_valid, out_data, out_err
   );

   modport slave (
      output in_valid, in_wen, in_sel, in_addr, in_wdata,
      output mem_ack, mem_rvalid, mem_rdata, mem_err,
      output out_ready,
      input  in_ready,
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  out_valid, out_data, out_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one EXU access at a time, checks alignment, runs the word-aligned
// memory req/ack handshake with byte strobes, and returns extended load data or store completion.
module lsu_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input logic        clk,
   input logic        rst,
   lsu_ctrl_if.master bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]            state;
   logic [7:0]            wait_cnt;
   logic [2:0]            sel_q;
   logic                  wen_q;
   logic [1:0]            off_q;

   logic                  is_byte;
   logic                  is_half;
   logic                  aligned;
   logic [3:0]            strobe;
   logic [4:0]            shamt;
   logic [DATA_WIDTH-1:0] rshift;
   logic [DATA_WIDTH-1:0] load_data;

   // Request decode; any funct3 outside the byte/half codes behaves as a word access.
   always_comb begin
      is_byte = (bus.in_sel == 3'b000) || (bus.in_sel == 3'b100);
      is_half = (bus.in_sel == 3'b001) || (bus.in_sel == 3'b101);
      aligned = is_byte || (is_half && !bus.in_addr[0]) || (bus.in_addr[1:0] == 2'b00);
      shamt   = {bus.in_addr[1:0], 3'b000};
      if (is_byte)
         strobe = 4'b0001 << bus.in_addr[1:0];
      else if (is_half)
         strobe = 4'b0011 << bus.in_addr[1:0];
      else
         strobe = 4'b1111;
   end

   always_comb begin
      rshift = bus.mem_rdata >> {off_q, 3'b000};
      case (sel_q)
         3'b000:  load_data = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
         3'b001:  load_data = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
         default: load_data = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         sel_q         <= '0;
         wen_q         <= 1'b0;
         off_q         <= '0;
         bus.in_ready  <= 1'b1;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wstrb <= '0;
         bus.mem_wdata <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sel_q        <= bus.in_sel;
                  wen_q        <= bus.in_wen;
                  off_q        <= bus.in_addr[1:0];
                  bus.in_ready <= 1'b0;
                  if (!aligned) begin
                     state         <= RESP;
                     bus.out_valid <= 1'b1;
                     bus.out_err   <= 1'b1;
                     bus.out_data  <= '0;
                  end else begin
                     state         <= REQ;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.in_wen;
                     bus.mem_addr  <= {bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
                     bus.mem_wstrb <= bus.in_wen ? strobe : 4'b0000;
                     bus.mem_wdata <= bus.in_wdata << shamt;
                  end
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  wait_cnt    <= '0;
                  state       <= WAIT;
               end
            end
            // A response wins over the timeout when both land in the final wait cycle.
            WAIT: begin
               if (bus.mem_rvalid) begin
                  state         <= RESP;
                  bus.out_valid <= 1'b1;
                  bus.out_err   <= bus.mem_err;
                  bus.out_data  <= (bus.mem_err || wen_q) ? '0 : load_data;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  state         <= RESP;
                  bus.out_valid <= 1'b1;
                  bus.out_err   <= 1'b1;
                  bus.out_data  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.out_err   <= 1'b0;
                  bus.out_data  <= '0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a cycle-stepped memory/WBU model drives each access and
// hand-computed expectations are compared through checkOutput.
module tb_lsu_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   lsu_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [31:0] MEMW = 32'h8070_F281;

   int          checkCount = 0;
   int          failCount  = 0;
   logic        obsReq, obsWe, obsErr;
   logic [31:0] obsAddr, obsWdata, obsData;
   logic [3:0]  obsStrb;
   int          obsLat;
   logic        stableBad, readyBad, done;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One access end to end: memory acks after ackDelay cycles, answers in the first wait cycle,
   // and the WBU holds off out_ready for readyDelay cycles.
   task automatic applyStimulus(input string tag, input logic wen, input logic [2:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ackDelay, input bit respond, input logic [31:0] rdata,
                                input logic rerr, input bit earlyRv, input int readyDelay);
      int c, reqCyc, waitCyc, respCyc;
      bit acked, gotValid, finishing;
      reqCyc = 0; waitCyc = 0; respCyc = 0;
      acked = 0; gotValid = 0; finishing = 0;
      obsReq = 0; obsWe = 0; obsErr = 0; obsAddr = '0; obsWdata = '0; obsData = '0; obsStrb = '0;
      obsLat = -1; stableBad = 0; readyBad = 0; done = 0;
      @(negedge clk);
      checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_wen = wen; bus.in_sel = sel; bus.in_addr = addr; bus.in_wdata = wdata;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_wen = ~wen; bus.in_sel = 3'b111;
      bus.in_addr = 32'hFFFF_FFFF; bus.in_wdata = 32'h0BAD_0BAD;
      c = 1;
      while (!done && c < 400) begin
         bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
         bus.out_ready = 1'b0; bus.mem_rdata = 32'h0;
         if (bus.in_ready) readyBad = 1'b1;
         if (bus.mem_req) begin
            if (!obsReq) begin
               obsWe = bus.mem_we; obsAddr = bus.mem_addr; obsStrb = bus.mem_wstrb; obsWdata = bus.mem_wdata;
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {obsWe, obsAddr, obsStrb, obsWdata}) begin
               stableBad = 1'b1;
            end
            obsReq = 1'b1;
            if (reqCyc >= ackDelay) begin
               bus.mem_ack = 1'b1;
               acked = 1'b1;
               if (earlyRv) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = ~rdata;
               end
            end
            reqCyc++;
         end else if (acked && !gotValid && !bus.out_valid) begin
            if (respond && waitCyc == 0) begin
               bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; bus.mem_err = rerr;
            end
            waitCyc++;
         end
         if (bus.out_valid) begin
            if (!gotValid) begin
               obsLat = c; obsData = bus.out_data; obsErr = bus.out_err; gotValid = 1'b1;
            end else if ({bus.out_data, bus.out_err} !== {obsData, obsErr}) begin
               stableBad = 1'b1;
            end
            if (respCyc >= readyDelay) begin
               bus.out_ready = 1'b1;
               finishing = 1'b1;
            end
            respCyc++;
         end
         @(negedge clk);
         c++;
         if (finishing) done = 1'b1;
      end
      bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0; bus.out_ready = 1'b0; bus.mem_rdata = 32'h0;
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_after"}, 32'({bus.out_valid, bus.in_ready}), 32'd1);
   endtask

   task automatic expectResult(input string tag, input logic expReq, input logic expWe,
                               input logic [31:0] expAddr, input logic [3:0] expStrb,
                               input logic [31:0] expWdata, input logic [31:0] expData,
                               input logic expErr, input int expLat);
      checkOutput({tag, "_req"}, 32'(obsReq), 32'(expReq));
      if (expReq) begin
         checkOutput({tag, "_we"}, 32'(obsWe), 32'(expWe));
         checkOutput({tag, "_addr"}, obsAddr, expAddr);
         checkOutput({tag, "_wstrb"}, 32'(obsStrb), 32'(expStrb));
         checkOutput({tag, "_wdata"}, obsWdata, expWdata);
      end
      checkOutput({tag, "_data"}, obsData, expData);
      checkOutput({tag, "_err"}, 32'(obsErr), 32'(expErr));
      checkOutput({tag, "_lat"}, 32'(obsLat), 32'(expLat));
      checkOutput({tag, "_stable"}, 32'(stableBad), 32'd0);
      checkOutput({tag, "_busy"}, 32'(readyBad), 32'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_sel = 3'b000; bus.in_addr = '0; bus.in_wdata = '0;
      bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_ctrl", 32'({bus.in_ready, bus.mem_req, bus.out_valid, bus.out_err}), 32'b1000);
      checkOutput("reset_addr", bus.mem_addr, 32'h0);
      checkOutput("reset_wstrb", 32'(bus.mem_wstrb), 32'h0);
      checkOutput("reset_data", bus.out_data, 32'h0);
      rst = 1'b1;

      applyStimulus("lb", 1'b0, 3'b000, 32'h101, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lb", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FFF2, 1'b0, 3);
      applyStimulus("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lhu", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h0000_8070, 1'b0, 3);
      applyStimulus("lh", 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lh", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_8070, 1'b0, 3);
      applyStimulus("lbu_early", 1'b0, 3'b100, 32'h103, 32'h0, 0, 1, MEMW, 1'b0, 1, 0);
      expectResult("lbu_early", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 3);
      applyStimulus("lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lw", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, MEMW, 1'b0, 3);
      applyStimulus("sh", 1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 0, 1, 32'h5555_AAAA, 1'b0, 0, 0);
      expectResult("sh", 1'b1, 1'b1, 32'h204, 4'b1100, 32'hABCD_0000, 32'h0, 1'b0, 3);
      applyStimulus("sw", 1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 0, 1, 32'h5555_AAAA, 1'b0, 0, 0);
      expectResult("sw", 1'b1, 1'b1, 32'h010, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
      applyStimulus("lw_mis", 1'b0, 3'b010, 32'h103, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lw_mis", 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lh_mis", 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus("sel011_mis", 1'b0, 3'b011, 32'h102, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("sel011_mis", 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
      applyStimulus("sb_slow", 1'b1, 3'b000, 32'h301, 32'h0000_0077, 5, 1, 32'h0, 1'b0, 0, 3);
      expectResult("sb_slow", 1'b1, 1'b1, 32'h300, 4'b0010, 32'h0000_7700, 32'h0, 1'b0, 8);
      applyStimulus("buserr", 1'b0, 3'b010, 32'h104, 32'h0, 0, 1, 32'h1234_5678, 1'b1, 0, 0);
      expectResult("buserr", 1'b1, 1'b0, 32'h104, 4'b0000, 32'h0, 32'h0, 1'b1, 3);
      applyStimulus("timeout", 1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h0, 1'b0, 0, 0);
      expectResult("timeout", 1'b1, 1'b0, 32'h400, 4'b0000, 32'h0, 32'h0, 1'b1, 6);

      // Reset in the middle of a wait, then a stray response that must be dropped.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_sel = 3'b010; bus.in_addr = 32'h100;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("rst_req_up", 32'(bus.mem_req), 32'd1);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rst_wait_drop", 32'({bus.mem_req, bus.out_valid, bus.in_ready}), 32'b001);
      @(negedge clk);
      rst = 1'b1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      checkOutput("rst_stray", 32'({bus.mem_req, bus.out_valid, bus.in_ready}), 32'b001);

      // Reset while a result is pending on the WBU side.
      bus.in_valid = 1'b1; bus.in_sel = 3'b010; bus.in_addr = 32'h103;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("rst_resp_up", 32'(bus.out_valid), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("rst_resp_drop", 32'({bus.out_valid, bus.out_err, bus.in_ready}), 32'b001);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus("lw_post_rst", 1'b0, 3'b010, 32'h100, 32'h0, 0, 1, MEMW, 1'b0, 0, 0);
      expectResult("lw_post_rst", 1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, MEMW, 1'b0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
